// File: rtl/lc3_datapath_p.sv
// Parametrised LC-3 datapath: PC/IR/MAR/MDR, eight-entry register file, ALU, address
// adder, NZP/BEN logic, shared bus and a request/acknowledge memory engine with timeout.
module lc3_datapath_p #(
   parameter int               WIDTH    = 16,
   parameter logic [WIDTH-1:0] RESET_PC = {WIDTH{1'b0}},
   parameter int               TIMEOUT  = 15
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             LD_MAR,
   input  logic             LD_MDR,
   input  logic             LD_IR,
   input  logic             LD_PC,
   input  logic             LD_CC,
   input  logic             LD_BEN,
   input  logic             LD_REG,
   input  logic             GatePC,
   input  logic             GateMDR,
   input  logic             GateALU,
   input  logic             GateMARMUX,
   input  logic [1:0]       PCMUX,
   input  logic [1:0]       ADDR2MUX,
   input  logic             ADDR1MUX,
   input  logic             SR1MUX,
   input  logic             SR2MUX,
   input  logic             DRMUX,
   input  logic [1:0]       ALUK,
   input  logic             MEM_RD,
   input  logic             MEM_WR,
   input  logic             clr_err,
   input  logic [WIDTH-1:0] mem_rdata,
   input  logic             mem_ack,
   output logic             mem_req,
   output logic             mem_we,
   output logic [WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   output logic [WIDTH-1:0] BUS,
   output logic [WIDTH-1:0] PC,
   output logic [WIDTH-1:0] IR,
   output logic [WIDTH-1:0] MAR,
   output logic [WIDTH-1:0] MDR,
   output logic [2:0]       NZP,
   output logic             BEN,
   output logic             mem_busy,
   output logic             mem_timeout,
   output logic             bus_conflict
);

   typedef enum logic [0:0] {S_IDLE = 1'b0, S_WAIT = 1'b1} mem_state_t;
   localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

   mem_state_t       state_r, state_nxt_s;
   logic [7:0]       cnt_r, cnt_nxt_s;
   logic [WIDTH-1:0] pc_r, ir_r, mar_r, mdr_r;
   logic [WIDTH-1:0] rf_r [0:7];
   logic [2:0]       nzp_r;
   logic             ben_r;
   logic [WIDTH-1:0] addr_r, wdata_r;
   logic             we_r, timeout_r, conflict_r;

   logic [WIDTH-1:0] sext5_s, sext6_s, sext9_s, sext11_s;
   logic [2:0]       sr1_idx_s, dr_idx_s;
   logic [WIDTH-1:0] sr1_s, sr2_s, addr1_s, addr2_s, adder_s, alu_s, bus_s, pc_nxt_s;
   logic [2:0]       gate_cnt_s, nzp_nxt_s;
   logic             conflict_evt_s, start_s, done_s, rd_done_s, timeout_evt_s;
   logic             unused_ir_s;

   assign sext5_s  = {{(WIDTH-5){ir_r[4]}}, ir_r[4:0]};
   assign sext6_s  = {{(WIDTH-6){ir_r[5]}}, ir_r[5:0]};
   assign sext9_s  = {{(WIDTH-9){ir_r[8]}}, ir_r[8:0]};
   assign sext11_s = {{(WIDTH-11){ir_r[10]}}, ir_r[10:0]};
   assign unused_ir_s = ^ir_r[WIDTH-1:12];

   assign sr1_idx_s = SR1MUX ? ir_r[11:9] : ir_r[8:6];
   assign dr_idx_s  = DRMUX ? 3'd7 : ir_r[11:9];
   assign sr1_s     = rf_r[sr1_idx_s];
   assign sr2_s     = SR2MUX ? sext5_s : rf_r[ir_r[2:0]];
   assign addr1_s   = ADDR1MUX ? sr1_s : pc_r;
   assign adder_s   = addr1_s + addr2_s;

   // ALU operation select
   always_comb begin
      alu_s = {WIDTH{1'b0}};
      case (ALUK)
         2'b00:   alu_s = sr1_s + sr2_s;
         2'b01:   alu_s = sr1_s & sr2_s;
         2'b10:   alu_s = ~sr1_s;
         2'b11:   alu_s = sr1_s;
         default: alu_s = {WIDTH{1'b0}};
      endcase
   end

   // Address adder B operand
   always_comb begin
      addr2_s = {WIDTH{1'b0}};
      case (ADDR2MUX)
         2'b00:   addr2_s = {WIDTH{1'b0}};
         2'b01:   addr2_s = sext6_s;
         2'b10:   addr2_s = sext9_s;
         2'b11:   addr2_s = sext11_s;
         default: addr2_s = {WIDTH{1'b0}};
      endcase
   end

   // Bus driver priority, PC highest
   always_comb begin
      bus_s = {WIDTH{1'b0}};
      if (GatePC)          bus_s = pc_r;
      else if (GateMDR)    bus_s = mdr_r;
      else if (GateALU)    bus_s = alu_s;
      else if (GateMARMUX) bus_s = adder_s;
      else                 bus_s = {WIDTH{1'b0}};
   end

   assign gate_cnt_s = {2'b00, GatePC} + {2'b00, GateMDR} + {2'b00, GateALU} + {2'b00, GateMARMUX};
   assign conflict_evt_s = (gate_cnt_s > 3'd1) | (MEM_RD & MEM_WR);

   assign nzp_nxt_s = bus_s[WIDTH-1] ? 3'b100 :
                      ((bus_s == {WIDTH{1'b0}}) ? 3'b010 : 3'b001);

   // PC next-value select
   always_comb begin
      pc_nxt_s = pc_r;
      case (PCMUX)
         2'b00:   pc_nxt_s = pc_r + {{(WIDTH-1){1'b0}}, 1'b1};
         2'b01:   pc_nxt_s = adder_s;
         2'b10:   pc_nxt_s = bus_s;
         2'b11:   pc_nxt_s = RESET_PC;
         default: pc_nxt_s = pc_r;
      endcase
   end

   // Memory engine next state; a simultaneous read and write strobe starts nothing
   always_comb begin
      state_nxt_s   = state_r;
      cnt_nxt_s     = cnt_r;
      start_s       = 1'b0;
      done_s        = 1'b0;
      rd_done_s     = 1'b0;
      timeout_evt_s = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (MEM_RD ^ MEM_WR) begin
               start_s     = 1'b1;
               cnt_nxt_s   = 8'd0;
               state_nxt_s = S_WAIT;
            end else begin
               state_nxt_s = S_IDLE;
            end
         end
         S_WAIT: begin
            if (mem_ack) begin
               done_s      = 1'b1;
               rd_done_s   = ~we_r;
               state_nxt_s = S_IDLE;
            end else if (cnt_r == TIMEOUT_C) begin
               done_s        = 1'b1;
               timeout_evt_s = 1'b1;
               state_nxt_s   = S_IDLE;
            end else begin
               cnt_nxt_s = cnt_r + 8'd1;
            end
         end
         default: state_nxt_s = S_IDLE;
      endcase
   end

   // Memory engine state and wait counter
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_r <= S_IDLE;
         cnt_r   <= 8'd0;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
      end
   end

   // Architectural registers; a read acknowledge overrides LD_MDR
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         pc_r  <= RESET_PC;
         ir_r  <= {WIDTH{1'b0}};
         mar_r <= {WIDTH{1'b0}};
         mdr_r <= {WIDTH{1'b0}};
         nzp_r <= 3'b000;
         ben_r <= 1'b0;
      end else begin
         if (LD_PC)  pc_r  <= pc_nxt_s;
         if (LD_IR)  ir_r  <= bus_s;
         if (LD_MAR) mar_r <= bus_s;
         if (rd_done_s)   mdr_r <= mem_rdata;
         else if (LD_MDR) mdr_r <= bus_s;
         if (LD_CC)  nzp_r <= nzp_nxt_s;
         if (LD_BEN) ben_r <= |(ir_r[11:9] & nzp_r);
      end
   end

   // Register file write port
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         for (int i = 0; i < 8; i++) rf_r[i] <= {WIDTH{1'b0}};
      end else if (LD_REG) begin
         rf_r[dr_idx_s] <= bus_s;
      end
   end

   // Request address/data are frozen at request start
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         addr_r  <= {WIDTH{1'b0}};
         wdata_r <= {WIDTH{1'b0}};
         we_r    <= 1'b0;
      end else if (start_s) begin
         addr_r  <= mar_r;
         wdata_r <= mdr_r;
         we_r    <= MEM_WR;
      end else if (done_s) begin
         we_r    <= 1'b0;
      end
   end

   // Sticky error flags; a new event outranks clr_err
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         timeout_r  <= 1'b0;
         conflict_r <= 1'b0;
      end else begin
         if (timeout_evt_s) timeout_r <= 1'b1;
         else if (clr_err)  timeout_r <= 1'b0;
         if (conflict_evt_s) conflict_r <= 1'b1;
         else if (clr_err)   conflict_r <= 1'b0;
      end
   end

   assign BUS          = bus_s;
   assign PC           = pc_r;
   assign IR           = ir_r;
   assign MAR          = mar_r;
   assign MDR          = mdr_r;
   assign NZP          = nzp_r;
   assign BEN          = ben_r;
   assign mem_req      = (state_r == S_WAIT);
   assign mem_busy     = (state_r == S_WAIT);
   assign mem_we       = we_r;
   assign mem_addr     = addr_r;
   assign mem_wdata    = wdata_r;
   assign mem_timeout  = timeout_r;
   assign bus_conflict = conflict_r;

endmodule

// File: tb/tb_lc3_datapath_p.sv
// Self-checking bench for lc3_datapath_p: a 16-bit instance with RESET_PC=3000 and a 32-bit
// instance share all controls; expectations come from an architectural model kept here.
module tb_lc3_datapath_p;
   localparam logic [15:0] RST_PC = 16'h3000;

   logic Clk = 1'b0, Reset = 1'b0;
   logic LD_MAR, LD_MDR, LD_IR, LD_PC, LD_CC, LD_BEN, LD_REG;
   logic GatePC, GateMDR, GateALU, GateMARMUX;
   logic [1:0] PCMUX, ADDR2MUX, ALUK;
   logic ADDR1MUX, SR1MUX, SR2MUX, DRMUX, MEM_RD, MEM_WR, clr_err, mem_ack;
   logic [31:0] mem_rdata;

   logic mem_req, mem_we, BEN, mem_busy, mem_timeout, bus_conflict;
   logic [15:0] mem_addr, mem_wdata, BUS, PC, IR, MAR, MDR;
   logic [2:0] NZP;
   logic mem_req_w, mem_we_w, BEN_w, mem_busy_w, mem_timeout_w, bus_conflict_w;
   logic [31:0] mem_addr_w, mem_wdata_w, BUS_w, PC_w, IR_w, MAR_w, MDR_w;
   logic [2:0] NZP_w;

   int n_checks = 0, n_fail = 0;
   logic [15:0] rf_m [0:7];
   logic [15:0] pc_m, ir_m, mdr_m;

   always #5 Clk = ~Clk;

   lc3_datapath_p #(.WIDTH(16), .RESET_PC(RST_PC), .TIMEOUT(15)) dut (
      .Clk(Clk), .Reset(Reset), .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_PC(LD_PC),
      .LD_CC(LD_CC), .LD_BEN(LD_BEN), .LD_REG(LD_REG), .GatePC(GatePC), .GateMDR(GateMDR),
      .GateALU(GateALU), .GateMARMUX(GateMARMUX), .PCMUX(PCMUX), .ADDR2MUX(ADDR2MUX),
      .ADDR1MUX(ADDR1MUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX), .DRMUX(DRMUX), .ALUK(ALUK),
      .MEM_RD(MEM_RD), .MEM_WR(MEM_WR), .clr_err(clr_err), .mem_rdata(mem_rdata[15:0]),
      .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .BUS(BUS), .PC(PC), .IR(IR), .MAR(MAR), .MDR(MDR), .NZP(NZP),
      .BEN(BEN), .mem_busy(mem_busy), .mem_timeout(mem_timeout), .bus_conflict(bus_conflict));

   lc3_datapath_p #(.WIDTH(32), .TIMEOUT(15)) dut_w (
      .Clk(Clk), .Reset(Reset), .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_PC(LD_PC),
      .LD_CC(LD_CC), .LD_BEN(LD_BEN), .LD_REG(LD_REG), .GatePC(GatePC), .GateMDR(GateMDR),
      .GateALU(GateALU), .GateMARMUX(GateMARMUX), .PCMUX(PCMUX), .ADDR2MUX(ADDR2MUX),
      .ADDR1MUX(ADDR1MUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX), .DRMUX(DRMUX), .ALUK(ALUK),
      .MEM_RD(MEM_RD), .MEM_WR(MEM_WR), .clr_err(clr_err), .mem_rdata(mem_rdata),
      .mem_ack(mem_ack), .mem_req(mem_req_w), .mem_we(mem_we_w), .mem_addr(mem_addr_w),
      .mem_wdata(mem_wdata_w), .BUS(BUS_w), .PC(PC_w), .IR(IR_w), .MAR(MAR_w), .MDR(MDR_w),
      .NZP(NZP_w), .BEN(BEN_w), .mem_busy(mem_busy_w), .mem_timeout(mem_timeout_w),
      .bus_conflict(bus_conflict_w));

   function automatic logic [15:0] sx(input logic [15:0] v, input int nb);
      logic signed [15:0] t;
      t = v << (16 - nb);
      return t >>> (16 - nb);
   endfunction

   function automatic logic [2:0] cc_of(input logic [15:0] v);
      if ($signed(v) < 0) return 3'b100;
      else if (v == 16'h0000) return 3'b010;
      else return 3'b001;
   endfunction

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic ctl_clear();
      {LD_MAR, LD_MDR, LD_IR, LD_PC, LD_CC, LD_BEN, LD_REG} = 7'b0;
      {GatePC, GateMDR, GateALU, GateMARMUX} = 4'b0;
      PCMUX = 2'b00; ADDR2MUX = 2'b00; ALUK = 2'b00;
      {ADDR1MUX, SR1MUX, SR2MUX, DRMUX, MEM_RD, MEM_WR, clr_err, mem_ack} = 8'b0;
   endtask

   task automatic load_mdr(input logic [31:0] v);
      MEM_RD = 1'b1; tick(); MEM_RD = 1'b0;
      mem_ack = 1'b1; mem_rdata = v; tick(); mem_ack = 1'b0;
      mdr_m = v[15:0];
   endtask

   task automatic set_ir(input logic [31:0] v);
      load_mdr(v);
      GateMDR = 1'b1; LD_IR = 1'b1; tick(); ctl_clear();
      ir_m = v[15:0];
   endtask

   task automatic write_reg(input logic [2:0] r, input logic [15:0] v);
      set_ir({20'h0, r, 9'h000});
      load_mdr({16'h0, v});
      GateMDR = 1'b1; LD_REG = 1'b1; tick(); ctl_clear();
      rf_m[r] = v;
   endtask

   task automatic test_reset();
      ctl_clear(); mem_rdata = 32'h0;
      #12; @(negedge Clk); Reset = 1'b1; #1;
      pc_m = RST_PC;
      n_checks++; if (PC !== RST_PC) begin n_fail++; $display("FAIL reset_pc: got %h want %h", PC, RST_PC); end
      n_checks++; if (NZP !== 3'b000 || BEN !== 1'b0) begin n_fail++; $display("FAIL reset_cc: got %b/%b want 000/0", NZP, BEN); end
      n_checks++; if ({mem_req, mem_busy, mem_we, mem_timeout, bus_conflict} !== 5'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 00000", {mem_req, mem_busy, mem_we, mem_timeout, bus_conflict}); end
      n_checks++; if ({MDR, IR, MAR, mem_addr, mem_wdata} !== 80'h0) begin n_fail++; $display("FAIL reset_regs: got %h want 0", {MDR, IR, MAR, mem_addr, mem_wdata}); end
      PCMUX = 2'b00; LD_PC = 1'b1; tick(); tick(); ctl_clear();
      pc_m = RST_PC + 16'd2;
      n_checks++; if (PC !== pc_m) begin n_fail++; $display("FAIL pc_inc: got %h want %h", PC, pc_m); end
   endtask

   task automatic test_alu_cc();
      write_reg(3'd1, 16'h7FFF); write_reg(3'd2, 16'h0001);
      set_ir(32'h0642);          // ADD R3 <- R1 + R2
      GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1; #1;
      n_checks++; if (BUS !== 16'h8000) begin n_fail++; $display("FAIL add_bus: got %h want 8000", BUS); end
      tick(); ctl_clear(); rf_m[3] = 16'h8000;
      n_checks++; if (NZP !== 3'b100) begin n_fail++; $display("FAIL add_cc: got %b want 100", NZP); end
      set_ir(32'h0860);          // AND R4 <- R1 & #0
      SR2MUX = 1'b1; ALUK = 2'b01; GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1; #1;
      n_checks++; if (BUS !== 16'h0000) begin n_fail++; $display("FAIL and_bus: got %h want 0000", BUS); end
      tick(); ctl_clear(); rf_m[4] = 16'h0000;
      n_checks++; if (NZP !== 3'b010) begin n_fail++; $display("FAIL and_cc: got %b want 010", NZP); end
      set_ir(32'h00C0);          // PASS R3
      ALUK = 2'b11; GateALU = 1'b1; #1;
      n_checks++; if (BUS !== 16'h8000) begin n_fail++; $display("FAIL r3_read: got %h want 8000", BUS); end
      ctl_clear();
   endtask

   task automatic test_width32();
      set_ir(32'h0);
      load_mdr(32'h7FFF_FFFF);
      GateMDR = 1'b1; LD_REG = 1'b1; tick(); ctl_clear();
      rf_m[0] = 16'hFFFF;
      set_ir(32'h0000_0201);     // R0 + #1
      SR2MUX = 1'b1; GateALU = 1'b1; LD_CC = 1'b1; #1;
      n_checks++; if (BUS_w !== 32'h8000_0000) begin n_fail++; $display("FAIL w32_bus: got %h want 80000000", BUS_w); end
      tick(); ctl_clear();
      n_checks++; if (NZP_w !== 3'b100) begin n_fail++; $display("FAIL w32_cc: got %b want 100", NZP_w); end
   endtask

   task automatic test_alu_random();
      logic [15:0] irv, a, b, res;
      logic [2:0] dr;
      for (int r = 0; r < 8; r++) write_reg(3'(r), 16'($urandom));
      for (int it = 0; it < 24; it++) begin
         irv = 16'($urandom);
         set_ir({16'h0, irv});
         SR1MUX = 1'($urandom); SR2MUX = 1'($urandom); DRMUX = 1'($urandom); ALUK = 2'($urandom);
         a = rf_m[SR1MUX ? irv[11:9] : irv[8:6]];
         b = SR2MUX ? sx(irv, 5) : rf_m[irv[2:0]];
         case (ALUK)
            2'b00: res = a + b;
            2'b01: res = a & b;
            2'b10: res = ~a;
            default: res = a;
         endcase
         dr = DRMUX ? 3'd7 : irv[11:9];
         GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1; #1;
         n_checks++; if (BUS !== res) begin n_fail++; $display("FAIL alu_rand%0d: got %h want %h", it, BUS, res); end
         tick(); ctl_clear(); rf_m[dr] = res;
         n_checks++; if (NZP !== cc_of(res)) begin n_fail++; $display("FAIL cc_rand%0d: got %b want %b", it, NZP, cc_of(res)); end
      end
      for (int r = 0; r < 8; r++) begin
         set_ir({16'h0, 7'h0, 3'(r), 6'h0});
         ALUK = 2'b11; GateALU = 1'b1; #1;
         n_checks++; if (BUS !== rf_m[r]) begin n_fail++; $display("FAIL rf_read%0d: got %h want %h", r, BUS, rf_m[r]); end
         ctl_clear();
      end
   endtask

   task automatic test_addr_random();
      logic [15:0] irv, a1, a2, sum;
      for (int it = 0; it < 16; it++) begin
         irv = 16'($urandom);
         set_ir({16'h0, irv});
         ADDR1MUX = 1'($urandom); SR1MUX = 1'($urandom); ADDR2MUX = 2'($urandom); PCMUX = 2'($urandom);
         a1 = ADDR1MUX ? rf_m[SR1MUX ? irv[11:9] : irv[8:6]] : pc_m;
         case (ADDR2MUX)
            2'b00: a2 = 16'h0;
            2'b01: a2 = sx(irv, 6);
            2'b10: a2 = sx(irv, 9);
            default: a2 = sx(irv, 11);
         endcase
         sum = a1 + a2;
         GateMARMUX = 1'b1; LD_PC = 1'b1; LD_MAR = 1'b1; #1;
         n_checks++; if (BUS !== sum) begin n_fail++; $display("FAIL adder%0d: got %h want %h", it, BUS, sum); end
         case (PCMUX)
            2'b00: pc_m = pc_m + 16'd1;
            2'b11: pc_m = RST_PC;
            default: pc_m = sum;
         endcase
         tick(); ctl_clear();
         n_checks++; if (PC !== pc_m || MAR !== sum) begin n_fail++; $display("FAIL pc_mar%0d: got %h/%h want %h/%h", it, PC, MAR, pc_m, sum); end
      end
   endtask

   task automatic test_read();
      load_mdr(32'h0040);
      GateMDR = 1'b1; LD_MAR = 1'b1; tick(); ctl_clear();
      MEM_RD = 1'b1; tick(); MEM_RD = 1'b0;
      n_checks++; if ({mem_req, mem_busy, mem_we} !== 3'b110 || mem_addr !== 16'h0040) begin n_fail++; $display("FAIL rd_start: got %b %h want 110 0040", {mem_req, mem_busy, mem_we}, mem_addr); end
      MEM_RD = 1'b1; GatePC = 1'b1; LD_MAR = 1'b1; tick(); ctl_clear();
      n_checks++; if (MAR !== pc_m || mem_addr !== 16'h0040 || mem_req !== 1'b1) begin n_fail++; $display("FAIL rd_busy_mar: got %h %h %b want %h 0040 1", MAR, mem_addr, mem_req, pc_m); end
      tick();
      mem_ack = 1'b1; mem_rdata = 32'hBEEF; GatePC = 1'b1; LD_MDR = 1'b1; tick(); ctl_clear();
      n_checks++; if (MDR !== 16'hBEEF || mem_busy !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL rd_ack: got %h %b%b want beef 00", MDR, mem_busy, mem_req); end
      tick();
      n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rd_ignored: got %b want 0", mem_req); end
      mem_ack = 1'b1; mem_rdata = 32'h1111; tick(); mem_ack = 1'b0;
      n_checks++; if (MDR !== 16'hBEEF || mem_busy !== 1'b0) begin n_fail++; $display("FAIL idle_ack: got %h %b want beef 0", MDR, mem_busy); end
      mdr_m = 16'hBEEF;
   endtask

   task automatic test_mem_random();
      logic [15:0] d;
      int lat;
      for (int it = 0; it < 10; it++) begin
         lat = $urandom_range(0, 10);
         d = 16'($urandom);
         if (it % 2 == 1) MEM_WR = 1'b1; else MEM_RD = 1'b1;
         tick(); ctl_clear();
         n_checks++; if (mem_req !== 1'b1 || mem_we !== 1'(it % 2) || (it % 2 == 1 && mem_wdata !== mdr_m)) begin n_fail++; $display("FAIL mem_start%0d: got %b %b %h want 1 %0d %h", it, mem_req, mem_we, mem_wdata, it % 2, mdr_m); end
         repeat (lat) tick();
         mem_ack = 1'b1; mem_rdata = {16'h0, d}; tick(); mem_ack = 1'b0;
         if (it % 2 == 0) mdr_m = d;
         n_checks++; if (MDR !== mdr_m || mem_busy !== 1'b0 || mem_timeout !== 1'b0) begin n_fail++; $display("FAIL mem_done%0d: got %h %b %b want %h 0 0", it, MDR, mem_busy, mem_timeout, mdr_m); end
      end
   endtask

   task automatic test_write_timeout();
      load_mdr(32'h1234);
      MEM_WR = 1'b1; tick(); MEM_WR = 1'b0;
      n_checks++; if (mem_we !== 1'b1 || mem_wdata !== 16'h1234 || mem_req !== 1'b1) begin n_fail++; $display("FAIL wr_start: got %b %h %b want 1 1234 1", mem_we, mem_wdata, mem_req); end
      GatePC = 1'b1; LD_MDR = 1'b1; tick(); ctl_clear();
      mdr_m = pc_m;
      n_checks++; if (MDR !== pc_m || mem_wdata !== 16'h1234) begin n_fail++; $display("FAIL wr_hold: got %h %h want %h 1234", MDR, mem_wdata, pc_m); end
      for (int i = 0; i < 14; i++) tick();
      n_checks++; if (mem_timeout !== 1'b0 || mem_req !== 1'b1) begin n_fail++; $display("FAIL to_early: got %b %b want 0 1", mem_timeout, mem_req); end
      tick();
      n_checks++; if (mem_timeout !== 1'b1 || mem_req !== 1'b0 || MDR !== mdr_m) begin n_fail++; $display("FAIL to_set: got %b %b %h want 1 0 %h", mem_timeout, mem_req, MDR, mdr_m); end
      clr_err = 1'b1; tick(); clr_err = 1'b0;
      n_checks++; if (mem_timeout !== 1'b0) begin n_fail++; $display("FAIL to_clear: got %b want 0", mem_timeout); end
   endtask

   task automatic test_contention();
      #1;
      n_checks++; if (BUS !== 16'h0000 || bus_conflict !== 1'b0) begin n_fail++; $display("FAIL bus_idle: got %h %b want 0000 0", BUS, bus_conflict); end
      GatePC = 1'b1; GateALU = 1'b1; #1;
      n_checks++; if (BUS !== pc_m) begin n_fail++; $display("FAIL bus_prio: got %h want %h", BUS, pc_m); end
      tick(); ctl_clear();
      n_checks++; if (bus_conflict !== 1'b1) begin n_fail++; $display("FAIL conflict_set: got %b want 1", bus_conflict); end
      clr_err = 1'b1; GatePC = 1'b1; GateMDR = 1'b1; tick(); ctl_clear();
      n_checks++; if (bus_conflict !== 1'b1) begin n_fail++; $display("FAIL clr_vs_new: got %b want 1", bus_conflict); end
      clr_err = 1'b1; tick(); ctl_clear();
      n_checks++; if (bus_conflict !== 1'b0) begin n_fail++; $display("FAIL conflict_clr: got %b want 0", bus_conflict); end
      MEM_RD = 1'b1; MEM_WR = 1'b1; tick(); ctl_clear();
      n_checks++; if (mem_req !== 1'b0 || mem_busy !== 1'b0 || bus_conflict !== 1'b1) begin n_fail++; $display("FAIL rdwr_both: got %b %b %b want 0 0 1", mem_req, mem_busy, bus_conflict); end
      clr_err = 1'b1; tick(); ctl_clear();
   endtask

   task automatic test_branch();
      logic [15:0] irv, v;
      logic [2:0] cc;
      for (int it = 0; it < 10; it++) begin
         irv = (it == 0) ? 16'h0400 : 16'($urandom);
         v = (it % 3 == 0) ? 16'h0000 : 16'($urandom);
         set_ir({16'h0, irv});
         load_mdr({16'h0, v});
         GateMDR = 1'b1; LD_CC = 1'b1; tick(); ctl_clear();
         cc = cc_of(v);
         n_checks++; if (NZP !== cc) begin n_fail++; $display("FAIL br_cc%0d: got %b want %b", it, NZP, cc); end
         LD_BEN = 1'b1; tick(); ctl_clear();
         n_checks++; if (BEN !== |(irv[11:9] & cc)) begin n_fail++; $display("FAIL ben%0d: got %b want %b", it, BEN, |(irv[11:9] & cc)); end
      end
   endtask

   task automatic test_reset_mid_access();
      MEM_RD = 1'b1; tick(); MEM_RD = 1'b0;
      n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL mid_req: got %b want 1", mem_req); end
      #2; Reset = 1'b0; #1;
      n_checks++; if (mem_req !== 1'b0 || mem_busy !== 1'b0 || PC !== RST_PC) begin n_fail++; $display("FAIL mid_reset: got %b %b %h want 0 0 %h", mem_req, mem_busy, PC, RST_PC); end
      @(negedge Clk); Reset = 1'b1;
      pc_m = RST_PC;
      load_mdr(32'hA5A5);
      n_checks++; if (MDR !== 16'hA5A5 || mem_busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_rd: got %h %b want a5a5 0", MDR, mem_busy); end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int r = 0; r < 8; r++) rf_m[r] = 16'h0;
      ir_m = 16'h0; mdr_m = 16'h0;
      test_reset();
      test_alu_cc();
      test_width32();
      test_alu_random();
      test_addr_random();
      test_read();
      test_mem_random();
      test_write_timeout();
      test_contention();
      test_branch();
      test_reset_mid_access();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/lc3_datapath_p.md
# lc3_datapath_p

Parametrised next-generation LC-3 datapath. It carries the PC, IR, MAR, MDR, the eight-entry register file, the ALU, the address adder, the NZP/BEN logic and the shared bus, generalised to any data width of 16 bits or more. New relative to the 16-bit datapath:
- an on-block memory-access engine with a request/acknowledge handshake and a cycle timeout;
- a programmable PC reset vector;
- sticky error flags for bus contention and memory timeout.

It sits between the control FSM and the memory/IO bridge.

## Interface
Parameters:
- WIDTH, 16: datapath width; legal values are 16 or more. IR fields stay at bits [15:0] and are sign-extended to WIDTH.
- RESET_PC, 0: PC value on reset and for PCMUX=11.
- TIMEOUT, 15: maximum wait cycles for mem_ack; legal range is 1–255.

Ports (name, direction, width, meaning):
- Clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- LD_MAR, LD_MDR, LD_IR, LD_PC, LD_CC, LD_BEN, LD_REG  in  1 each  register load enables.
- GatePC, GateMDR, GateALU, GateMARMUX  in  1 each  bus drivers.
- PCMUX  in  2  PC next-value select: 00 PC+1, 01 adder, 10 bus, 11 RESET_PC.
- ADDR2MUX  in  2  adder B operand: 00 zero, 01 sext IR[5:0], 10 sext IR[8:0], 11 sext IR[10:0].
- ADDR1MUX, SR1MUX, SR2MUX, DRMUX  in  1 each  ADDR1MUX: 0 PC, 1 SR1. SR1MUX: 0 IR[8:6], 1 IR[11:9]. SR2MUX: 0 reg IR[2:0], 1 sext IR[4:0]. DRMUX: 0 IR[11:9], 1 R7.
- ALUK  in  2  ALU operation: 00 ADD, 01 AND, 10 NOT A, 11 PASS A.
- MEM_RD, MEM_WR  in  1 each  one-cycle memory-access start strobes.
- clr_err  in  1  clears both sticky error flags.
- mem_rdata  in  WIDTH  read data from memory.
- mem_ack  in  1  memory completion.
- mem_req  out  1  request active.
- mem_we  out  1  1 = write.
- mem_addr, mem_wdata  out  WIDTH  address and write data, latched when the request starts.
- BUS, PC, IR, MAR, MDR  out  WIDTH  current values.
- NZP  out  3  condition codes {N,Z,P}.
- BEN  out  1  branch enable.
- mem_busy  out  1  memory engine not idle.
- mem_timeout, bus_conflict  out  1 each  sticky error flags.

## Operation
- Bus:
  - Priority PC > MDR > ALU > MARMUX.
  - No gate active drives BUS = 0.
  - Two or more gates active in the same cycle sets bus_conflict.
- Adder output is ADDR1 + ADDR2, modulo 2^WIDTH. GateMARMUX drives the adder output.
- ALU arithmetic wraps modulo 2^WIDTH.
- Register file:
  - Eight registers, WIDTH bits each.
  - Write from BUS to the DRMUX-selected register on LD_REG.
  - Reads are combinational.
  - A same-cycle write and read returns the old value.
- CC on LD_CC, computed from signed BUS:
  - N = BUS[WIDTH-1].
  - Z = (BUS == 0).
  - P = otherwise.
- BEN on LD_BEN: |(IR[11:9] & NZP).
- Memory engine states:
  - IDLE: MEM_RD xor MEM_WR moves to WAIT. mem_addr is taken from MAR, mem_wdata from MDR, and mem_we from MEM_WR. The wait counter clears.
  - WAIT:
    - mem_req = 1.
    - mem_ack = 1 returns to IDLE. On a read, MDR loads mem_rdata on that edge.
    - Otherwise the counter increments. Counter == TIMEOUT sets mem_timeout and returns to IDLE; MDR is unchanged.
- Boundary rules:
  - MEM_RD and MEM_WR high together: no request, bus_conflict set.
  - MEM_RD or MEM_WR while busy: ignored.
  - LD_MDR in the same cycle as a read ack: the ack wins.
  - LD_MAR or LD_MDR while busy: registers load normally; mem_addr and mem_wdata are unaffected.
  - clr_err together with a new error in the same cycle: the flag stays set.

## Timing
- Reset values:
  - PC = RESET_PC; all other registers, NZP and BEN = 0.
  - FSM = IDLE.
  - mem_req, mem_we, mem_busy and both error flags = 0.
  - mem_addr and mem_wdata = 0.
- Registered loads are visible one cycle after the enable cycle.
- BUS and the muxes are combinational.
- Memory handshake:
  - A strobe at cycle t gives mem_req = 1 from t+1.
  - mem_ack sampled at edge t+k ends the access; mem_req = 0 and mem_busy = 0 from t+k+1.
  - mem_ack seen at the earliest point gives minimum latency of 2 cycles from strobe to MDR valid.
- Timeout: mem_timeout is set TIMEOUT+1 cycles after mem_req rises.
- mem_ack while IDLE is ignored.
- Reset asserted mid-access forces IDLE and drops mem_req immediately.

## Test plan
- Reset check (WIDTH=16, RESET_PC=16'h3000): release Reset -> PC=3000, NZP=000, mem_req=0. Then PCMUX=00 with LD_PC for 2 cycles -> PC=3002.
- ALU and CC:
  - R1=7FFF, R2=0001, ADD, GateALU, LD_REG, LD_CC -> DR=8000, NZP=100.
  - AND with imm5=0 -> result 0, NZP=010.
  - Repeat with WIDTH=32: 7FFFFFFF+1 gives N=1.
- Read:
  - MAR=0040, MEM_RD, mem_ack after 3 cycles with mem_rdata=BEEF -> MDR=BEEF on the ack edge and mem_busy low the next cycle.
  - A second MEM_RD while busy is ignored.
- Write and timeout:
  - MEM_WR with MDR=1234 -> mem_we=1, mem_wdata=1234; a later change of MDR leaves mem_wdata unchanged.
  - With no ack and TIMEOUT=15 -> mem_timeout=1 sixteen cycles after mem_req rises; MDR unchanged; clr_err clears the flag.
- Contention: GatePC=1 and GateALU=1 -> BUS=PC and bus_conflict=1. MEM_RD=1 and MEM_WR=1 -> no mem_req and bus_conflict stays 1.
- Branch and reset mid-access:
  - IR[11:9]=010 with NZP=010 and LD_BEN -> BEN=1.
  - Reset low during WAIT -> mem_req=0 immediately; after release the engine is IDLE and a fresh read completes.
